// File: rtl/softex_slot_cache.sv
// softex_slot_cache: fully associative store of per-row softmax state (max, den) keyed by slot address.
// Define SOFTEX_SLOT_CACHE_LRU_EN to evict the least-recently-used entry on an ALLOC miss when full.
module softex_slot_cache #(
  parameter int               N_SLOTS  = 8,
  parameter int               ADDR_W   = 8,
  parameter int               MAX_W    = 16,
  parameter int               DEN_W    = 32,
  parameter logic [MAX_W-1:0] MAX_INIT = 16'hFF80,
  localparam int              OCC_W    = $clog2(N_SLOTS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic              rsp_err_o,
  output logic [MAX_W-1:0]  rsp_max_o,
  output logic [DEN_W-1:0]  rsp_den_o,
  input  logic              upd_valid_i,
  input  logic              upd_op_i,
  input  logic [ADDR_W-1:0] upd_addr_i,
  input  logic [MAX_W-1:0]  upd_max_i,
  input  logic [DEN_W-1:0]  upd_den_i,
  output logic              evict_valid_o,
  output logic [ADDR_W-1:0] evict_addr_o,
  output logic [MAX_W-1:0]  evict_max_o,
  output logic [DEN_W-1:0]  evict_den_o,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic              full_o
);
  localparam int IDX_W = $clog2(N_SLOTS);
  typedef logic [IDX_W-1:0] idx_t;

  logic [N_SLOTS-1:0] valid_q, valid_u, valid_d;
  logic [ADDR_W-1:0]  tag_q [N_SLOTS];
  logic [ADDR_W-1:0]  tag_d [N_SLOTS];
  logic [MAX_W-1:0]   max_q [N_SLOTS];
  logic [MAX_W-1:0]   max_u [N_SLOTS];
  logic [MAX_W-1:0]   max_d [N_SLOTS];
  logic [DEN_W-1:0]   den_q [N_SLOTS];
  logic [DEN_W-1:0]   den_u [N_SLOTS];
  logic [DEN_W-1:0]   den_d [N_SLOTS];

  logic accept, upd_en, hit, has_free, fill;
  idx_t hit_idx, free_idx, fill_idx;

  logic              rsp_valid_q, rsp_hit_q, rsp_err_q, evict_q;
  logic [MAX_W-1:0]  rsp_max_q, evict_max_q;
  logic [DEN_W-1:0]  rsp_den_q, evict_den_q;
  logic [ADDR_W-1:0] evict_addr_q;
  logic              rsp_hit_d, rsp_err_d, evict_d;
  logic [MAX_W-1:0]  rsp_max_d, evict_max_d;
  logic [DEN_W-1:0]  rsp_den_d, evict_den_d;
  logic [ADDR_W-1:0] evict_addr_d;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o && !clear_i;
  assign upd_en      = upd_valid_i && !clear_i;

  // Apply this cycle's UPDATE/FREE first so the request observes post-update state.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid_u = valid_q;
    max_u   = max_q;
    den_u   = den_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (upd_en && valid_q[i] && tag_q[i] == upd_addr_i) begin
        if (upd_op_i) begin
          valid_u[i] = 1'b0;
        end else begin
          max_u[i] = upd_max_i;
          den_u[i] = upd_den_i;
        end
      end
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (valid_u[i] && tag_q[i] == req_addr_i) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
    end
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!valid_u[i]) begin
        has_free = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end

`ifdef SOFTEX_SLOT_CACHE_LRU_EN
  idx_t       age_q [N_SLOTS];
  idx_t       age_d [N_SLOTS];
  idx_t       victim, touch_idx;
  logic       touch;
  logic [IDX_W:0] old_age;

  // Only consulted when every entry is valid; strict '>' keeps the lowest index on a tie.
  always_comb begin
    victim = '0;
    for (int i = 1; i < N_SLOTS; i++) begin
      if (age_q[i] > age_q[victim]) victim = idx_t'(i);
    end
  end

  always_comb begin
    age_d     = age_q;
    touch     = accept && (hit || fill);
    touch_idx = hit ? hit_idx : fill_idx;
    old_age   = hit      ? {1'b0, age_q[hit_idx]} :
                has_free ? (IDX_W+1)'(N_SLOTS) : {1'b0, age_q[victim]};
    if (touch) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (valid_u[i] && idx_t'(i) != touch_idx && {1'b0, age_q[i]} < old_age)
          age_d[i] = age_q[i] + idx_t'(1);
      end
      age_d[touch_idx] = '0;
    end
    if (clear_i) age_d = '{default: '0};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) age_q <= '{default: '0};
    else       age_q <= age_d;
  end
`endif

  always_comb begin
    rsp_hit_d    = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_max_d    = '0;
    rsp_den_d    = '0;
    evict_d      = 1'b0;
    evict_addr_d = '0;
    evict_max_d  = '0;
    evict_den_d  = '0;
    fill         = 1'b0;
    fill_idx     = free_idx;
    if (hit) begin
      rsp_hit_d = 1'b1;
      rsp_max_d = max_u[hit_idx];
      rsp_den_d = den_u[hit_idx];
    end else if (!req_op_i) begin
      if (has_free) begin
        fill      = 1'b1;
        rsp_max_d = MAX_INIT;
      end else begin
`ifdef SOFTEX_SLOT_CACHE_LRU_EN
        fill         = 1'b1;
        fill_idx     = victim;
        evict_d      = 1'b1;
        evict_addr_d = tag_q[victim];
        evict_max_d  = max_u[victim];
        evict_den_d  = den_u[victim];
        rsp_max_d    = MAX_INIT;
`else
        rsp_err_d = 1'b1;
`endif
      end
    end

    valid_d = valid_u;
    tag_d   = tag_q;
    max_d   = max_u;
    den_d   = den_u;
    if (accept && fill) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = req_addr_i;
      max_d[fill_idx]   = MAX_INIT;
      den_d[fill_idx]   = '0;
    end
    if (clear_i) valid_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_max_q    <= '0;
      rsp_den_q    <= '0;
      evict_q      <= 1'b0;
      evict_addr_q <= '0;
      evict_max_q  <= '0;
      evict_den_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (clear_i) begin
        rsp_valid_q <= 1'b0;
      end else if (accept) begin
        rsp_valid_q  <= 1'b1;
        rsp_hit_q    <= rsp_hit_d;
        rsp_err_q    <= rsp_err_d;
        rsp_max_q    <= rsp_max_d;
        rsp_den_q    <= rsp_den_d;
        evict_q      <= evict_d;
        evict_addr_q <= evict_addr_d;
        evict_max_q  <= evict_max_d;
        evict_den_q  <= evict_den_d;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: payload arrays are left unreset; the valid bits gate every read, so reset costs nothing functionally.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    max_q <= max_d;
    den_q <= den_d;
  end

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < N_SLOTS; i++) occupancy_o = occupancy_o + OCC_W'(valid_q[i]);
  end

  assign full_o        = occupancy_o == OCC_W'(N_SLOTS);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_hit_o     = rsp_hit_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_max_o     = rsp_max_q;
  assign rsp_den_o     = rsp_den_q;
  assign evict_valid_o = evict_q && rsp_valid_q;
  assign evict_addr_o  = evict_addr_q;
  assign evict_max_o   = evict_max_q;
  assign evict_den_o   = evict_den_q;
endmodule

// File: tb/tb_softex_slot_cache.sv
// Testbench for softex_slot_cache: directed vector table, corner sequences, and random traffic
// against a recency-ordered queue model (honours SOFTEX_SLOT_CACHE_LRU_EN).
module tb_softex_slot_cache;
  localparam int N = 8;

  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_hit, rsp_err;
  logic [15:0] rsp_max;
  logic [31:0] rsp_den;
  logic        upd_valid = 1'b0, upd_op = 1'b0;
  logic [7:0]  upd_addr = '0;
  logic [15:0] upd_max = '0;
  logic [31:0] upd_den = '0;
  logic        ev_valid;
  logic [7:0]  ev_addr;
  logic [15:0] ev_max;
  logic [31:0] ev_den;
  logic [3:0]  occ;
  logic        full;

  softex_slot_cache dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit), .rsp_err_o(rsp_err),
    .rsp_max_o(rsp_max), .rsp_den_o(rsp_den),
    .upd_valid_i(upd_valid), .upd_op_i(upd_op), .upd_addr_i(upd_addr),
    .upd_max_i(upd_max), .upd_den_i(upd_den),
    .evict_valid_o(ev_valid), .evict_addr_o(ev_addr), .evict_max_o(ev_max), .evict_den_o(ev_den),
    .occupancy_o(occ), .full_o(full)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: resident entries ordered most-recently-used first, plus the pending response.
  typedef struct { logic [7:0] addr; logic [15:0] mx; logic [31:0] den; } ent_t;
  typedef struct {
    logic hit, err, ev;
    logic [15:0] mx; logic [31:0] den;
    logic [7:0] ev_addr; logic [15:0] ev_max; logic [31:0] ev_den;
  } rsp_t;
  ent_t rec_q[$];
  rsp_t exp_rsp;
  logic pend = 1'b0;

  function automatic int find(logic [7:0] a);
    foreach (rec_q[i]) if (rec_q[i].addr == a) return i;
    return -1;
  endfunction

  function automatic rsp_t serve(logic op, logic [7:0] a);
    rsp_t r = '{default: '0};
    ent_t e;
    int k = find(a);
    if (k >= 0) begin
      e = rec_q[k];
      r.hit = 1'b1; r.mx = e.mx; r.den = e.den;
      rec_q.delete(k);
      rec_q.push_front(e);
    end else if (op == 1'b0) begin
      if (rec_q.size() == N) begin
`ifdef SOFTEX_SLOT_CACHE_LRU_EN
        e = rec_q.pop_back();
        r.ev = 1'b1; r.ev_addr = e.addr; r.ev_max = e.mx; r.ev_den = e.den;
`else
        r.err = 1'b1;
        return r;
`endif
      end
      r.mx = 16'hFF80;
      e = '{addr: a, mx: 16'hFF80, den: 32'h0};
      rec_q.push_front(e);
    end
    return r;
  endfunction

  task automatic check_outputs();
    check("rsp_valid", rsp_valid, pend);
    check("req_ready", req_ready, !pend || rsp_ready);
    check("occupancy", occ, rec_q.size());
    check("full", full, rec_q.size() == N);
    check("evict_valid", ev_valid, pend && exp_rsp.ev);
    if (pend) begin
      check("rsp_hit", rsp_hit, exp_rsp.hit);
      check("rsp_err", rsp_err, exp_rsp.err);
      check("rsp_max", rsp_max, exp_rsp.mx);
      check("rsp_den", rsp_den, exp_rsp.den);
      if (exp_rsp.ev) begin
        check("evict_addr", ev_addr, exp_rsp.ev_addr);
        check("evict_max", ev_max, exp_rsp.ev_max);
        check("evict_den", ev_den, exp_rsp.ev_den);
      end
    end
  endtask

  // One clock: check outputs at negedge, advance the model with the driven inputs, return at posedge+1.
  task automatic tick();
    ent_t e;
    int k;
    @(negedge clk);
    check_outputs();
    if (clear) begin
      rec_q.delete();
      pend = 1'b0;
    end else begin
      if (upd_valid) begin
        k = find(upd_addr);
        if (k >= 0) begin
          if (upd_op) rec_q.delete(k);
          else begin
            e = rec_q[k]; e.mx = upd_max; e.den = upd_den; rec_q[k] = e;
          end
        end
      end
      if (req_valid && (!pend || rsp_ready)) begin
        exp_rsp = serve(req_op, req_addr);
        pend = 1'b1;
      end else if (rsp_ready) begin
        pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; upd_valid = 1'b0; clear = 1'b0;
  endtask

  typedef struct {
    logic uv, uop; logic [7:0] ua; logic [15:0] um; logic [31:0] ud;
    logic rv, rop; logic [7:0] ra;
    logic hit; logic [15:0] mx; logic [31:0] den; logic [3:0] occ;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 0, 8'h00, 16'h0000, 32'h0,        1, 0, 8'h05, 0, 16'hFF80, 32'h0,        4'd1};
    vecs[1] = '{1, 0, 8'h05, 16'h3F80, 32'h40000000, 0, 0, 8'h00, 0, 16'h0000, 32'h0,        4'd1};
    vecs[2] = '{0, 0, 8'h00, 16'h0000, 32'h0,        1, 1, 8'h05, 1, 16'h3F80, 32'h40000000, 4'd1};
    vecs[3] = '{0, 0, 8'h00, 16'h0000, 32'h0,        1, 1, 8'h06, 0, 16'h0000, 32'h0,        4'd1};
    vecs[4] = '{0, 0, 8'h00, 16'h0000, 32'h0,        1, 0, 8'h03, 0, 16'hFF80, 32'h0,        4'd2};
    vecs[5] = '{1, 1, 8'h03, 16'h0000, 32'h0,        1, 0, 8'h03, 0, 16'hFF80, 32'h0,        4'd2};
    vecs[6] = '{0, 0, 8'h00, 16'h0000, 32'h0,        1, 0, 8'h05, 1, 16'h3F80, 32'h40000000, 4'd2};
    vecs[7] = '{1, 0, 8'h06, 16'h1111, 32'h2222,     1, 1, 8'h06, 0, 16'h0000, 32'h0,        4'd2};
    vecs[8] = '{1, 1, 8'h05, 16'h0000, 32'h0,        0, 0, 8'h00, 0, 16'h0000, 32'h0,        4'd1};
    vecs[9] = '{0, 0, 8'h00, 16'h0000, 32'h0,        1, 1, 8'h05, 0, 16'h0000, 32'h0,        4'd1};

    // Reset values
    #12;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_hit", rsp_hit, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_max", rsp_max, 0);
    check("reset_rsp_den", rsp_den, 0);
    check("reset_evict_valid", ev_valid, 0);
    check("reset_evict_addr", ev_addr, 0);
    check("reset_occupancy", occ, 0);
    check("reset_full", full, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one per cycle with rsp_ready held high
    foreach (vecs[i]) begin
      upd_valid = vecs[i].uv; upd_op = vecs[i].uop; upd_addr = vecs[i].ua;
      upd_max = vecs[i].um; upd_den = vecs[i].ud;
      req_valid = vecs[i].rv; req_op = vecs[i].rop; req_addr = vecs[i].ra;
      tick();
      check("vec_rsp_valid", rsp_valid, vecs[i].rv);
      if (vecs[i].rv) begin
        check("vec_rsp_hit", rsp_hit, vecs[i].hit);
        check("vec_rsp_err", rsp_err, 0);
        check("vec_rsp_max", rsp_max, vecs[i].mx);
        check("vec_rsp_den", rsp_den, vecs[i].den);
      end
      check("vec_occupancy", occ, vecs[i].occ);
    end
    idle();

    // Fill all slots, touch all but the first, then ALLOC a new address while full
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_occupancy", occ, 0);
    for (int a = 0; a < N; a++) begin
      req_valid = 1'b1; req_op = 1'b0; req_addr = 8'(8'h10 + a); tick();
    end
    req_valid = 1'b0;
    upd_valid = 1'b1; upd_op = 1'b0; upd_addr = 8'h10; upd_max = 16'h1234; upd_den = 32'h5678;
    tick(); upd_valid = 1'b0;
    check("fill_full", full, 1);
    for (int a = 1; a < N; a++) begin
      req_valid = 1'b1; req_op = 1'b1; req_addr = 8'(8'h10 + a); tick();
    end
    req_op = 1'b0; req_addr = 8'h20; tick(); req_valid = 1'b0;
`ifdef SOFTEX_SLOT_CACHE_LRU_EN
    check("evict_valid_full", ev_valid, 1);
    check("evict_addr_full", ev_addr, 8'h10);
    check("evict_max_full", ev_max, 16'h1234);
    check("evict_den_full", ev_den, 32'h5678);
    check("evict_rsp_err", rsp_err, 0);
    check("evict_rsp_max", rsp_max, 16'hFF80);
`else
    check("full_rsp_err", rsp_err, 1);
    check("full_rsp_hit", rsp_hit, 0);
    check("full_rsp_max", rsp_max, 0);
    check("full_evict_valid", ev_valid, 0);
`endif
    tick();
    check("full_after_alloc", full, 1);

    // Backpressure: first response held, second request stalled, then drained in order
    rsp_ready = 1'b0; req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h11; tick();
    req_addr = 8'h55;
    check("bp_req_ready", req_ready, 0);
    tick(); tick();
    check("bp_first_held", rsp_hit, 1);
    rsp_ready = 1'b1; tick(); req_valid = 1'b0;
    check("bp_second_valid", rsp_valid, 1);
    check("bp_second_order", rsp_hit, 0);
    tick();

    // Clear with a response pending
    rsp_ready = 1'b0; req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h11; tick();
    req_valid = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    check("clear_rsp_valid", rsp_valid, 0);
    check("clear_occ", occ, 0);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'h11; tick(); req_valid = 1'b0;
    check("clear_load_miss", rsp_hit, 0);
    tick();

    // Random traffic over a small address range so hits, fills and full-cache ALLOCs all occur
    for (int c = 0; c < 3000; c++) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_op    = $urandom_range(0, 2) == 0;
      req_addr  = 8'($urandom_range(0, 11));
      upd_valid = $urandom_range(0, 2) == 0;
      upd_op    = $urandom_range(0, 3) == 0;
      upd_addr  = 8'($urandom_range(0, 11));
      upd_max   = 16'($urandom);
      upd_den   = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      clear     = $urandom_range(0, 199) == 0;
      tick();
    end
    idle();

    // Asynchronous reset with a response pending
    rsp_ready = 1'b0; req_valid = 1'b1; req_op = 1'b0; req_addr = 8'h01; tick();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_occ", occ, 0);
    check("async_rst_req_ready", req_ready, 1);
    rec_q.delete();
    pend = 1'b0;
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/softex_slot_cache.md
# softex_slot_cache

Parametrised, fully associative store for per-row softmax running state (maximum, denominator) keyed by a slot address. It sits between the SoftEx controller and datapath and generalises the fixed slot register file to N_SLOTS tagged entries. It serves ALLOC/LOAD requests through a registered valid/ready response channel, accepts UPDATE/FREE writes, and optionally evicts the least-recently-used entry when full.

## Interface
- N_SLOTS, 8, number of entries (≥2)
- ADDR_W, 8, slot address (tag) width
- MAX_W, 16, maximum field width (FPFORMAT_IN)
- DEN_W, 32, denominator field width (FPFORMAT_ACC)
- MAX_INIT, 16'hFF80, maximum written on allocation (-inf in FP16ALT)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous flush: invalidate all entries, drop pending response
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_op_i  in  1  0 = ALLOC, 1 = LOAD
- req_addr_i  in  ADDR_W  requested slot address
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_hit_o  out  1  address was resident
- rsp_err_o  out  1  ALLOC refused (full, eviction disabled)
- rsp_max_o  out  MAX_W  slot maximum
- rsp_den_o  out  DEN_W  slot denominator
- upd_valid_i  in  1  update strobe (always accepted)
- upd_op_i  in  1  0 = UPDATE, 1 = FREE
- upd_addr_i  in  ADDR_W  target address
- upd_max_i, upd_den_i  in  MAX_W, DEN_W  UPDATE data
- evict_valid_o  out  1  response carries an evicted entry
- evict_addr_o, evict_max_o, evict_den_o  out  ADDR_W, MAX_W, DEN_W  evicted contents
- occupancy_o  out  $clog2(N_SLOTS+1)  valid entry count
- full_o  out  1  occupancy_o == N_SLOTS

## Operation
- Lookup: compare addr against tags of all valid entries; at most one match by construction.
- ALLOC hit: rsp_hit=1, stored values returned, no state change.
- ALLOC miss, free entry: lowest-index invalid entry set valid, tag=addr, max=MAX_INIT, den=0; rsp_hit=0, init values returned.
- ALLOC miss, full: see Configuration.
- LOAD hit: rsp_hit=1, stored values. LOAD miss: rsp_hit=0, max/den=0, no allocation.
- UPDATE hit: overwrite max/den. FREE hit: clear valid. Any update miss: ignored.
- Same-cycle update and accepted request: update applied first; request observes post-update state (FREE then ALLOC of same addr → miss, reallocated with init values).
- clear_i: all entries invalid, rsp_valid_o=0; same-cycle request and update discarded.
- Reset: all entries invalid, every output 0 except req_ready_o=1.

## Timing
- Request accepted when req_valid_i && req_ready_o; req_ready_o = !rsp_valid_o || rsp_ready_i.
- Response registered: rsp_valid_o rises the cycle after acceptance; all rsp_*/evict_* outputs stable until handshake.
- Throughput 1 request/cycle with rsp_ready_i held high.
- State change, occupancy_o and full_o take effect the cycle after acceptance/update.
- Update writes take one cycle; no backpressure on the update port.
- Reset mid-transaction: pending response discarded immediately (asynchronous).

## Configuration
- SOFTEX_SLOT_CACHE_LRU_EN defined: per-entry age counters ($clog2(N_SLOTS) bits). Any hit or fill touches an entry: its age becomes 0 and valid entries younger than its old age increment. ALLOC miss when full evicts the oldest entry, lowest index on tie. The evicted entry is refilled as a fresh allocation; evict_valid_o=1 with old tag/max/den; rsp_err_o=0.
- Undefined: no age logic. ALLOC miss when full returns rsp_err_o=1, rsp_hit_o=0, data 0, no state change; evict_valid_o tied 0.

## Test plan
- Reset, ALLOC 0x05 → rsp_hit=0, max=0xFF80, den=0, occupancy_o=1 next cycle.
- UPDATE 0x05 (max=0x3F80, den=0x40000000), then LOAD 0x05 → hit=1, max=0x3F80, den=0x40000000; LOAD 0x06 → hit=0, data 0.
- Fill 8 slots, ALLOC 0x20: without macro → rsp_err=1, full_o stays 1. With macro, after touching slots 1..7 → evict_valid=1, evicted entry is slot 0's.
- FREE 0x03 and ALLOC 0x03 in same cycle → rsp_hit=0, init values, occupancy unchanged.
- Hold rsp_ready_i=0 with two requests queued → req_ready_o=0, first response held stable. Release → back-to-back responses in order.
- Assert clear_i with rsp_valid_o=1 → next cycle rsp_valid_o=0, occupancy_o=0; LOAD of any prior address misses.
